// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared types and constants for the data-memory responder.
//   state_e      : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   DATA_W/SEL_W : bus data width and byte-enable width
//   CNT_W        : wait-state counter width (WAIT_CYCLES up to 15)
//   ZERO_WORD    : all-zero bus word
//   req_err()    : request rejection rule (misaligned full-word access, or an
//                  address beyond the implemented RAM)
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

   localparam int DATA_W = 32;
   localparam int SEL_W  = 4;
   localparam int CNT_W  = 4;

   localparam logic [DATA_W-1:0] ZERO_WORD = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // A full-word access must be word aligned; partial-lane accesses may carry
   // any low address bits. Any set bit above the RAM's byte range is an error.
   function automatic logic req_err(input logic [31:0]      addr,
                                    input logic [SEL_W-1:0] sel,
                                    input int unsigned      addr_w);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[1:0] != 2'b00) && (sel == 4'b1111);
      out_of_range = ((addr >> (addr_w + 2)) != 32'd0);
      return misaligned || out_of_range;
   endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// -----------------------------------------------------------------------------
// data_ram_array
// Word-organised RAM, 2**ADDR_W x 32, one byte-wide array per lane so every
// lane has its own write enable. Read data is registered and only updates when
// re_i is high, so it holds the last word read. Contents are not reset.
// Ports:
//   clk      in  1       rising-edge clock
//   we_i     in  4       per-lane write enable; we_i[i] writes wdata_i[8i+7:8i]
//   re_i     in  1       read strobe; rdata_o updates on the next edge
//   addr_i   in  ADDR_W  word index
//   wdata_i  in  32      write data
//   rdata_o  out 32      registered read data
// -----------------------------------------------------------------------------
module data_ram_array
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic [SEL_W-1:0]  we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   genvar gi;
   generate
      for (gi = 0; gi < SEL_W; gi++) begin : g_lane
         logic [7:0] mem_q [DEPTH];
         logic [7:0] rdata_q;

         always_ff @(posedge clk) begin
            if (we_i[gi]) begin
               mem_q[addr_i] <= wdata_i[8*gi +: 8];
            end
            if (re_i) begin
               rdata_q <= mem_q[addr_i];
            end
         end

         assign rdata_o[8*gi +: 8] = rdata_q;
      end
   endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Data-memory slave for MEM-stage loads and stores. One request outstanding at
// a time: the request is captured in IDLE, optionally waits WAIT_CYCLES cycles,
// then completes with a one-cycle ack_o in RESP. The RAM write (store) or read
// (load) happens on the edge that enters RESP. stall_o holds the pipeline for
// as long as a request is presented and not yet acknowledged.
// Parameters:
//   ADDR_W       word-address width; RAM depth is 2**ADDR_W words
//   WAIT_CYCLES  extra cycles between accept and ack (0..15)
// Ports:
//   clk         in  1   rising-edge clock
//   rst         in  1   synchronous active-high reset
//   mem_ce_i    in  1   request valid, held stable until ack_o
//   mem_we_i    in  1   1 = store, 0 = load
//   mem_sel_i   in  4   byte enables
//   mem_addr_i  in  32  byte address
//   mem_data_i  in  32  store data
//   mem_data_o  out 32  load data, valid with ack_o when err_o=0
//   ack_o       out 1   one-cycle completion pulse
//   stall_o     out 1   pipeline hold request
//   err_o       out 1   request rejected, valid with ack_o
// -----------------------------------------------------------------------------
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_ce_i,
   input  logic              mem_we_i,
   input  logic [SEL_W-1:0]  mem_sel_i,
   input  logic [31:0]       mem_addr_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              ack_o,
   output logic              stall_o,
   output logic              err_o
);

   localparam logic [CNT_W-1:0] WAIT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Latched request
   logic               we_q, we_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [ADDR_W-1:0]  widx_q, widx_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               err_q, err_d;

   // Last completed load word, held between load acks
   logic [DATA_W-1:0]  data_q, data_d;

   // Request as seen this cycle: live inputs while IDLE (so a zero-wait
   // request can hit the RAM on its accept edge), latched copy otherwise.
   logic               cur_we;
   logic [SEL_W-1:0]   cur_sel;
   logic [ADDR_W-1:0]  cur_widx;
   logic [DATA_W-1:0]  cur_wdata;
   logic               cur_err;

   logic               enter_resp;
   logic [SEL_W-1:0]   ram_we;
   logic               ram_re;
   logic [DATA_W-1:0]  ram_rdata;

   always_comb begin
      cur_we    = we_q;
      cur_sel   = sel_q;
      cur_widx  = widx_q;
      cur_wdata = wdata_q;
      cur_err   = err_q;
      if (state_q == ST_IDLE) begin
         cur_we    = mem_we_i;
         cur_sel   = mem_sel_i;
         cur_widx  = mem_addr_i[ADDR_W+1:2];
         cur_wdata = mem_data_i;
         cur_err   = req_err(mem_addr_i, mem_sel_i, ADDR_W);
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      sel_d   = sel_q;
      widx_d  = widx_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      data_d  = data_q;

      case (state_q)
         ST_IDLE: begin
            if (mem_ce_i) begin
               we_d    = cur_we;
               sel_d   = cur_sel;
               widx_d  = cur_widx;
               wdata_d = cur_wdata;
               err_d   = cur_err;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            // A rejected load also counts as a load completion and leaves zero.
            if (!we_q) begin
               data_d = err_q ? ZERO_WORD : ram_rdata;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // RAM access happens on the edge into RESP; reset suppresses it so a
   // request interrupted by reset never commits.
   assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP) && !rst;
   assign ram_we     = (enter_resp && cur_we && !cur_err) ? cur_sel : '0;
   assign ram_re     = enter_resp && !cur_we && !cur_err;

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         widx_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         data_q  <= ZERO_WORD;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         widx_q  <= widx_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      ack_o      = (state_q == ST_RESP);
      err_o      = ack_o && err_q;
      mem_data_o = data_q;
      if (ack_o) begin
         if (err_q) begin
            mem_data_o = ZERO_WORD;
         end else if (!we_q) begin
            mem_data_o = ram_rdata;
         end
      end
   end

   assign stall_o = mem_ce_i && !ack_o;

   data_ram_array #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (cur_widx),
      .wdata_i (cur_wdata),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Two responders share clk/rst: instance 0 has WAIT_CYCLES=0, instance 1 has
// WAIT_CYCLES=1. A reference model (word array plus the last load value per
// instance) predicts ack latency, err, read data and held output.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce    [2];
   logic        we    [2];
   logic [3:0]  sel   [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [31:0] rdata [2];
   logic        ack   [2];
   logic        stall [2];
   logic        err   [2];

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         data_mem_responder #(
            .ADDR_W      (10),
            .WAIT_CYCLES (gi)
         ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .mem_ce_i   (ce[gi]),
            .mem_we_i   (we[gi]),
            .mem_sel_i  (sel[gi]),
            .mem_addr_i (addr[gi]),
            .mem_data_i (wdata[gi]),
            .mem_data_o (rdata[gi]),
            .ack_o      (ack[gi]),
            .stall_o    (stall[gi]),
            .err_o      (err[gi])
         );
      end
   endgenerate

   int total = 0;
   int bad   = 0;

   logic [31:0] model [2][1024];
   logic [31:0] held  [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic model_err(input logic [31:0] a, input logic [3:0] s);
      return ((a % 4) != 0 && s == 4'hF) || (a >= 32'h1000);
   endfunction

   // One complete request on instance k; returns once the block is idle again.
   task automatic txn(input int k, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] d);
      logic        e;
      int          n;
      int          widx;
      logic [31:0] exp_data;
      e    = model_err(a, s);
      widx = int'((a / 4) % 1024);
      ce[k] = 1'b1; we[k] = w; sel[k] = s; addr[k] = a; wdata[k] = d;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (!ack[k]) chk("stall_wait", {31'd0, stall[k]}, 32'd1);
      end while (!ack[k] && n < 40);
      chk("latency", n, k + 1);
      if (e) begin
         exp_data = 32'd0;
         if (!w) held[k] = 32'd0;
      end else if (w) begin
         for (int i = 0; i < 4; i++)
            if (s[i]) model[k][widx][8*i +: 8] = d[8*i +: 8];
         exp_data = held[k];
      end else begin
         exp_data = model[k][widx];
         held[k]  = exp_data;
      end
      chk("ack_stall", {31'd0, stall[k]}, 32'd0);
      chk("err", {31'd0, err[k]}, {31'd0, e});
      chk("ack_data", rdata[k], exp_data);
      $display("txn dut=%0d we=%0b sel=%h addr=%h wdata=%h rdata=%h err=%0b lat=%0d",
               k, w, s, a, d, rdata[k], err[k], n);
      ce[k] = 1'b0;
      @(posedge clk); #1;
      chk("idle_ack", {31'd0, ack[k]}, 32'd0);
      chk("hold", rdata[k], held[k]);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         ce[k] = 1'b0; we[k] = 1'b0; sel[k] = 4'h0; addr[k] = 32'd0; wdata[k] = 32'd0;
         held[k] = 32'd0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_ack",   {31'd0, ack[k]},   32'd0);
         chk("rst_err",   {31'd0, err[k]},   32'd0);
         chk("rst_stall", {31'd0, stall[k]}, 32'd0);
         chk("rst_data",  rdata[k],          32'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Known contents for words 0..16 on both instances
      for (int k = 0; k < 2; k++)
         for (int w = 0; w < 17; w++)
            txn(k, 1'b1, 4'hF, 32'(w * 4), $urandom);

      // Reset in the middle of a waiting store: nothing commits, outputs clear
      txn(1, 1'b1, 4'hF, 32'h10, 32'h01020304);
      txn(1, 1'b0, 4'hF, 32'h10, 32'd0);
      ce[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; addr[1] = 32'h10; wdata[1] = 32'hDEADBEEF;
      @(posedge clk); #1;
      chk("t1_accept_noack", {31'd0, ack[1]}, 32'd0);
      rst = 1'b1;
      ce[1] = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         chk("t1_rst_ack",  {31'd0, ack[1]}, 32'd0);
         chk("t1_rst_err",  {31'd0, err[1]}, 32'd0);
         chk("t1_rst_data", rdata[1],        32'd0);
      end
      rst = 1'b0;
      held[0] = 32'd0;
      held[1] = 32'd0;
      @(posedge clk); #1;
      chk("t1_post_ack", {31'd0, ack[1]}, 32'd0);
      txn(1, 1'b0, 4'hF, 32'h10, 32'd0);
      chk("t1_word", rdata[1], 32'h01020304);

      // Full store then load, then partial-lane store over it
      txn(1, 1'b1, 4'hF, 32'h20, 32'h11223344);
      txn(1, 1'b0, 4'hF, 32'h20, 32'd0);
      chk("t2_word", rdata[1], 32'h11223344);
      txn(1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
      txn(1, 1'b0, 4'hF, 32'h20, 32'd0);
      chk("t3_word", rdata[1], 32'h11BB33DD);

      // Rejected requests: misaligned full word, beyond RAM
      txn(1, 1'b0, 4'hF, 32'h22, 32'd0);
      txn(1, 1'b0, 4'hF, 32'h1000, 32'd0);
      txn(1, 1'b1, 4'hF, 32'h1020, 32'hCAFEF00D);
      txn(1, 1'b0, 4'hF, 32'h20, 32'd0);
      chk("t4_word", rdata[1], 32'h11BB33DD);

      // Zero-lane store is a no-op that still acks
      txn(1, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF);
      txn(1, 1'b0, 4'hF, 32'h30, 32'd0);

      // Zero-wait instance with ce held across three loads
      txn(0, 1'b1, 4'hF, 32'h40, 32'h55667788);
      ce[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF; addr[0] = 32'h40; wdata[0] = 32'd0;
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         chk("t5_ack",   {31'd0, ack[0]},   {31'd0, 1'(i % 2)});
         chk("t5_stall", {31'd0, stall[0]}, {31'd0, 1'((i + 1) % 2)});
         if (i % 2 == 1) chk("t5_data", rdata[0], 32'h55667788);
         $display("txn dut=0 held-ce cycle=%0d ack=%0b stall=%0b rdata=%h", i, ack[0], stall[0], rdata[0]);
      end
      ce[0] = 1'b0;
      held[0] = 32'h55667788;
      @(posedge clk); #1;
      chk("t5_idle_ack", {31'd0, ack[0]}, 32'd0);

      // Randomised traffic on both instances
      for (int k = 0; k < 2; k++) begin
         for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [3:0]  s;
            int          kind;
            kind = int'($urandom_range(0, 9));
            a    = 32'($urandom_range(0, 16)) * 4;
            s    = 4'($urandom);
            if (kind == 0)      a = a | (32'h1000 << $urandom_range(0, 19));
            else if (kind == 1) begin a = a + 32'($urandom_range(1, 3)); s = 4'hF; end
            else if (kind == 2) a = a + 32'($urandom_range(1, 3));
            txn(k, 1'($urandom), s, a, $urandom);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
